tl_handshake_monitor: RTL and testbench
=======================================

Name: tl_handshake_monitor

Overview:
Parametrised, synthesizable successor to the single-cycle channel-exclusion assertion checkers. It watches NCH valid/ready channels that share one downstream sink. Per cycle it checks that at most one channel fires. Over time it checks valid persistence, payload stability and wait-time bound, recording sticky error state readable by software/debug as well as optionally stopping simulation. Sits alongside bus crossbars and arbiters as a passive observer; drives nothing on the bus.

Parameters:
NCH, 4, number of monitored channels (>=2)
DATA_W, 32, payload width per channel
TIMEOUT, 256, max cycles valid may wait for ready; 0 disables timeout check
CNT_W, 8, error event counter width
FATAL_EN, 1, 1 = non-synthesis $fatal on any new error; 0 = flags only

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
chk_dis  in  1  1 = suppress all checking; channel trackers forced to IDLE
err_clr  in  1  synchronous clear of sticky flags, counter and capture
valid  in  NCH  per-channel valid
ready  in  NCH  per-channel ready
data  in  NCH*DATA_W  per-channel payload, channel i at [i*DATA_W +: DATA_W]
err_mutex  out  1  sticky: >1 channel fired in one cycle
err_drop  out  NCH  sticky: valid withdrawn before handshake
err_data  out  NCH  sticky: payload changed while waiting
err_timeout  out  NCH  sticky: wait reached TIMEOUT cycles
err_any  out  1  OR of all sticky flags
err_count  out  CNT_W  saturating count of cycles with >=1 new error
first_vld  out  1  first-error capture valid
first_type  out  2  0 mutex, 1 drop, 2 data, 3 timeout
first_chan  out  max(1,clog2(NCH))  channel of first error (0 for mutex)

Behaviour:
- Reset (async assert, sync-safe deassert by system): all outputs 0, all trackers IDLE, counters 0, held data 0.
- fire[i] = valid[i] & ready[i]. Mutex event when popcount(fire) > 1.
- Per-channel FSM, IDLE/WAIT:
  - IDLE -> WAIT when valid & ~ready; latch data into hold[i]; wait counter := 1.
  - WAIT, valid & ready -> IDLE (normal handshake); data compared this cycle too.
  - WAIT, valid & ~ready -> stay; counter increments, saturating at TIMEOUT.
  - WAIT, ~valid -> drop event; -> IDLE.
  - WAIT, valid & data != hold[i] -> data event (hold NOT updated; one event per cycle of mismatch, flag sticky).
- Timeout event when counter transitions to TIMEOUT (exactly once per wait episode); TIMEOUT=0 never fires. TIMEOUT=1: fires on first cycle in WAIT.
- All events evaluated combinationally in cycle N; sticky flags, counter, capture update at edge ending cycle N (visible cycle N+1).
- err_count += 1 per cycle with any new event, regardless of event count; holds at 2^CNT_W-1.
- First-error capture loads only when first_vld=0; same-cycle priority: lowest type code, then lowest channel index.
- err_clr: clears sticky flags, err_count, capture; does not touch FSMs. Clear and new event same cycle: event wins (flag set, count = 1, capture loads).
- chk_dis=1: no events generated, FSMs held IDLE, sticky state retained. Deassertion mid-handshake starts fresh tracking (no spurious drop).
- FATAL_EN=1 and not SYNTHESIS: $fatal on any new event when reset low; plain message print otherwise. Excluded from synthesis.
- Outputs are registered; no combinational path input->output.

Test Plan:
- NCH=4: valid=4'b0011, ready=4'b0011 for one cycle -> next cycle err_mutex=1, err_count=1, first_type=0, first_chan=0.
- ch2 valid high, ready low 3 cycles, data constant 0xA5A5_0000, then ready -> no errors; FSM back to IDLE; err_any=0.
- ch1 waits 2 cycles then valid drops -> err_drop=4'b0010, first_type=1, first_chan=1.
- ch3 waiting, data changes 0x1 -> 0x2 -> err_data[3]=1; same cycle ch0 dropped -> first_type=1, first_chan=0 (priority), err_count +1 only.
- TIMEOUT=4: ch0 valid, ready low 10 cycles -> err_timeout[0] set after 4th wait cycle, count increments once; err_clr with simultaneous new mutex -> err_mutex=1, err_timeout=0, err_count=1.
- CNT_W=2: 5 error cycles -> err_count=3; assert reset mid-WAIT -> all outputs 0 immediately, no drop reported after release.

Source files
------------

// File: rtl/tl_handshake_monitor.sv
// tl_handshake_monitor
// Passive observer for NCH valid/ready channels that share one sink.
// Flags more than one handshake per cycle, valid withdrawn before ready,
// payload changing while stalled, and stalls reaching TIMEOUT cycles.
// All flags are sticky. There is a saturating error-cycle counter and a
// first-error capture. Every output is registered.
module tl_handshake_monitor #(
   parameter int NCH      = 4,
   parameter int DATA_W   = 32,
   parameter int TIMEOUT  = 256,
   parameter int CNT_W    = 8,
   parameter int FATAL_EN = 1,
   localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    chk_dis,
   input  logic                    err_clr,
   input  logic [NCH-1:0]          valid,
   input  logic [NCH-1:0]          ready,
   input  logic [NCH*DATA_W-1:0]   data,
   output logic                    err_mutex,
   output logic [NCH-1:0]          err_drop,
   output logic [NCH-1:0]          err_data,
   output logic [NCH-1:0]          err_timeout,
   output logic                    err_any,
   output logic [CNT_W-1:0]        err_count,
   output logic                    first_vld,
   output logic [1:0]              first_type,
   output logic [CHW-1:0]          first_chan
);

   localparam int              TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0]   TO_V    = TW'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;
   typedef enum logic [1:0] {
      ET_MUTEX   = 2'd0,
      ET_DROP    = 2'd1,
      ET_DATA    = 2'd2,
      ET_TIMEOUT = 2'd3
   } err_type_t;

   // Per-channel tracker state
   state_t              state    [NCH];
   state_t              state_nx [NCH];
   logic [TW-1:0]       wcnt     [NCH];
   logic [TW-1:0]       wcnt_nx  [NCH];
   logic [DATA_W-1:0]   hold     [NCH];
   logic [NCH-1:0]      ld_hold;

   // Events of the current cycle
   logic [NCH-1:0]      fire;
   logic                ev_mutex;
   logic [NCH-1:0]      ev_drop;
   logic [NCH-1:0]      ev_data;
   logic [NCH-1:0]      ev_to;
   logic                new_any;

   // Next values of the error-reporting registers
   logic                mutex_nx;
   logic [NCH-1:0]      drop_nx;
   logic [NCH-1:0]      data_nx;
   logic [NCH-1:0]      to_nx;
   logic [CNT_W-1:0]    count_base;
   logic [CNT_W-1:0]    count_nx;
   logic                fvld_nx;
   err_type_t           ftype_nx;
   logic [CHW-1:0]      fchan_nx;

   function automatic logic [CHW-1:0] lowest_idx(input logic [NCH-1:0] v);
      lowest_idx = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (v[i]) lowest_idx = CHW'(i);
      end
   endfunction

   // Event detection and next state of each channel tracker
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path
      // leaves one unassigned and no latch is inferred.
      fire     = valid & ready;
      ev_mutex = ~chk_dis & ($countones(fire) > 1);
      for (int i = 0; i < NCH; i++) begin
         state_nx[i] = state[i];
         wcnt_nx[i]  = wcnt[i];
         ld_hold[i]  = 1'b0;
         ev_drop[i]  = 1'b0;
         ev_data[i]  = 1'b0;
         ev_to[i]    = 1'b0;
         if (chk_dis) begin
            state_nx[i] = ST_IDLE;
         end else if (state[i] == ST_IDLE) begin
            if (valid[i] && !ready[i]) begin
               state_nx[i] = ST_WAIT;
               wcnt_nx[i]  = TW'(1);
               ld_hold[i]  = 1'b1;
               ev_to[i]    = (TIMEOUT == 1);
            end
         end else if (!valid[i]) begin
            ev_drop[i]  = 1'b1;
            state_nx[i] = ST_IDLE;
         end else begin
            ev_data[i] = (data[i*DATA_W +: DATA_W] != hold[i]);
            if (ready[i]) begin
               state_nx[i] = ST_IDLE;
            end else if (wcnt[i] != TO_V) begin
               wcnt_nx[i] = wcnt[i] + TW'(1);
               ev_to[i]   = (TIMEOUT != 0) && ((wcnt[i] + TW'(1)) == TO_V);
            end
         end
      end
      new_any = ev_mutex | (|ev_drop) | (|ev_data) | (|ev_to);
   end

   // Sticky state: a clear empties it first, then this cycle's events are
   // layered on top, so an event in the clearing cycle survives the clear
   always_comb begin
      mutex_nx   = (err_clr ? 1'b0 : err_mutex) | ev_mutex;
      drop_nx    = (err_clr ? '0 : err_drop) | ev_drop;
      data_nx    = (err_clr ? '0 : err_data) | ev_data;
      to_nx      = (err_clr ? '0 : err_timeout) | ev_to;
      count_base = err_clr ? '0 : err_count;
      count_nx   = count_base;
      if (new_any && (count_base != CNT_MAX)) count_nx = count_base + CNT_W'(1);
      fvld_nx  = err_clr ? 1'b0 : first_vld;
      ftype_nx = err_clr ? ET_MUTEX : err_type_t'(first_type);
      fchan_nx = err_clr ? '0 : first_chan;
      if (!fvld_nx && new_any) begin
         fvld_nx = 1'b1;
         if (ev_mutex) begin
            ftype_nx = ET_MUTEX;
            fchan_nx = '0;
         end else if (|ev_drop) begin
            ftype_nx = ET_DROP;
            fchan_nx = lowest_idx(ev_drop);
         end else if (|ev_data) begin
            ftype_nx = ET_DATA;
            fchan_nx = lowest_idx(ev_data);
         end else begin
            ftype_nx = ET_TIMEOUT;
            fchan_nx = lowest_idx(ev_to);
         end
      end
   end

   // Channel trackers: IDLE/WAIT state, wait counter and held payload
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the values from before this edge.
      if (reset) begin
         for (int i = 0; i < NCH; i++) begin
            state[i] <= ST_IDLE;
            wcnt[i]  <= '0;
            // NOTE: the hold registers are reset even though they act as
            // storage, because a cleared monitor must show no stale payload.
            hold[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            state[i] <= state_nx[i];
            wcnt[i]  <= wcnt_nx[i];
            if (ld_hold[i]) hold[i] <= data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Registered error outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         err_mutex   <= 1'b0;
         err_drop    <= '0;
         err_data    <= '0;
         err_timeout <= '0;
         err_any     <= 1'b0;
         err_count   <= '0;
         first_vld   <= 1'b0;
         first_type  <= 2'd0;
         first_chan  <= '0;
      end else begin
         err_mutex   <= mutex_nx;
         err_drop    <= drop_nx;
         err_data    <= data_nx;
         err_timeout <= to_nx;
         err_any     <= mutex_nx | (|drop_nx) | (|data_nx) | (|to_nx);
         err_count   <= count_nx;
         first_vld   <= fvld_nx;
         first_type  <= ftype_nx;
         first_chan  <= fchan_nx;
      end
   end

`ifndef SYNTHESIS
   // Simulation-only reporting of each cycle that raises a new event
   always @(posedge clock) begin
      if (!reset && new_any) begin
         if (FATAL_EN != 0)
            $fatal(1, "tl_handshake_monitor: protocol event (mutex=%0b drop=%b data=%b timeout=%b)",
                   ev_mutex, ev_drop, ev_data, ev_to);
         else
            $info("tl_handshake_monitor: protocol event (mutex=%0b drop=%b data=%b timeout=%b)",
                  ev_mutex, ev_drop, ev_data, ev_to);
      end
   end
`endif

endmodule

// File: tb/tb_tl_handshake_monitor.sv
// Testbench for tl_handshake_monitor: directed scenarios followed by random
// traffic, compared against a transaction-level reference model.
module tb_tl_handshake_monitor;

   localparam int NCH     = 4;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int VW      = 1 + 3*NCH + 1 + CNT_W + 1 + 2 + 2;

   logic                  clock = 1'b0;
   logic                  reset;
   logic                  chk_dis;
   logic                  err_clr;
   logic [NCH-1:0]        valid;
   logic [NCH-1:0]        ready;
   logic [NCH*DATA_W-1:0] data;
   logic                  err_mutex;
   logic [NCH-1:0]        err_drop;
   logic [NCH-1:0]        err_data;
   logic [NCH-1:0]        err_timeout;
   logic                  err_any;
   logic [CNT_W-1:0]      err_count;
   logic                  first_vld;
   logic [1:0]            first_type;
   logic [1:0]            first_chan;

   int checks = 0;
   int errors = 0;

   // Reference model: per-channel "stalled" flag, stall length, payload
   // seen at stall start, plus the expected reporting state.
   bit                m_wait [NCH];
   int                m_len  [NCH];
   logic [DATA_W-1:0] m_hold [NCH];
   logic              m_mutex;
   logic [NCH-1:0]    m_drop, m_data, m_to;
   int                m_count;
   logic              m_fvld;
   logic [1:0]        m_ftype, m_fchan;

   tl_handshake_monitor #(
      .NCH(NCH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .FATAL_EN(0)
   ) dut (
      .clock(clock), .reset(reset), .chk_dis(chk_dis), .err_clr(err_clr),
      .valid(valid), .ready(ready), .data(data),
      .err_mutex(err_mutex), .err_drop(err_drop), .err_data(err_data),
      .err_timeout(err_timeout), .err_any(err_any), .err_count(err_count),
      .first_vld(first_vld), .first_type(first_type), .first_chan(first_chan)
   );

   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [VW-1:0] dut_vec();
      return {err_mutex, err_drop, err_data, err_timeout, err_any, err_count,
              first_vld, first_type, first_chan};
   endfunction

   function automatic logic [VW-1:0] model_vec();
      logic any;
      any = m_mutex | (|m_drop) | (|m_data) | (|m_to);
      return {m_mutex, m_drop, m_data, m_to, any, CNT_W'(m_count),
              m_fvld, m_ftype, m_fchan};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_wait[i] = 0; m_len[i] = 0; m_hold[i] = '0;
      end
      m_mutex = 0; m_drop = '0; m_data = '0; m_to = '0;
      m_count = 0; m_fvld = 0; m_ftype = 0; m_fchan = 0;
   endtask

   // Apply one clock's worth of the rules to the inputs present at the edge.
   task automatic model_update();
      logic [NCH-1:0]    ev [4];
      logic [DATA_W-1:0] d;
      bit                any, found;
      if (reset) begin
         model_reset();
         return;
      end
      for (int t = 0; t < 4; t++) ev[t] = '0;
      ev[0][0] = !chk_dis && ($countones(valid & ready) > 1);
      for (int i = 0; i < NCH; i++) begin
         d = data[i*DATA_W +: DATA_W];
         if (chk_dis) begin
            m_wait[i] = 0;
         end else if (m_wait[i] && !valid[i]) begin
            ev[1][i] = 1'b1;
            m_wait[i] = 0;
         end else if (valid[i]) begin
            if (m_wait[i] && d != m_hold[i]) ev[2][i] = 1'b1;
            if (ready[i]) begin
               m_wait[i] = 0;
            end else begin
               if (!m_wait[i]) begin
                  m_hold[i] = d;
                  m_len[i]  = 0;
               end
               m_wait[i] = 1;
               m_len[i]++;
               if (TIMEOUT > 0 && m_len[i] == TIMEOUT) ev[3][i] = 1'b1;
            end
         end
      end
      any = (ev[0] | ev[1] | ev[2] | ev[3]) != '0;
      if (err_clr) begin
         m_mutex = 0; m_drop = '0; m_data = '0; m_to = '0;
         m_count = 0; m_fvld = 0; m_ftype = 0; m_fchan = 0;
      end
      m_mutex = m_mutex | ev[0][0];
      m_drop  = m_drop | ev[1];
      m_data  = m_data | ev[2];
      m_to    = m_to | ev[3];
      if (any && m_count < CNT_MAX) m_count++;
      if (any && !m_fvld) begin
         m_fvld = 1;
         found  = 0;
         for (int t = 0; t < 4; t++)
            for (int c = 0; c < NCH; c++)
               if (!found && ev[t][c]) begin
                  m_ftype = 2'(t); m_fchan = 2'(c); found = 1;
               end
      end
   endtask

   // One clock: edge, model step, then settle before sampling.
   task automatic cycle();
      @(posedge clock);
      model_update();
      #1;
   endtask

   task automatic set_data(input int ch, input logic [DATA_W-1:0] v);
      data[ch*DATA_W +: DATA_W] = v;
   endtask

   task automatic idle_inputs();
      valid = '0; ready = '0; chk_dis = 0; err_clr = 0;
   endtask

   task automatic test_reset();
      reset = 1; idle_inputs(); data = '0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (dut_vec() !== '0) begin
         errors++; $display("FAIL reset_state: got %h want 0", dut_vec());
      end
      reset = 0;
   endtask

   task automatic test_mutex();
      valid = 4'b0011; ready = 4'b0011;
      cycle();
      checks++;
      if ({err_mutex, err_count, first_vld, first_type, first_chan} !== {1'b1, 2'd1, 1'b1, 2'd0, 2'd0}) begin
         errors++;
         $display("FAIL mutex: got m=%b cnt=%0d fv=%b ft=%0d fc=%0d want 1 1 1 0 0",
                  err_mutex, err_count, first_vld, first_type, first_chan);
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
         errors++; $display("FAIL mutex_model: got %h want %h", dut_vec(), model_vec());
      end
      idle_inputs(); err_clr = 1;
      cycle();
      err_clr = 0;
      checks++;
      if (dut_vec() !== '0) begin
         errors++; $display("FAIL mutex_clear: got %h want 0", dut_vec());
      end
   endtask

   task automatic test_handshake();
      valid = 4'b0100; ready = '0; set_data(2, 32'hA5A5_0000);
      for (int k = 0; k < 3; k++) begin
         cycle();
         checks++;
         if (err_any !== 1'b0) begin
            errors++; $display("FAIL hs_wait%0d: err_any got %b want 0", k, err_any);
         end
      end
      ready = 4'b0100;
      cycle();
      checks++;
      if (dut_vec() !== model_vec() || err_any !== 1'b0) begin
         errors++; $display("FAIL hs_done: got %h want %h", dut_vec(), model_vec());
      end
      idle_inputs();
      cycle();
      checks++;
      if (dut_vec() !== '0) begin
         errors++; $display("FAIL hs_idle: got %h want 0 (tracker not idle)", dut_vec());
      end
   endtask

   task automatic test_drop();
      valid = 4'b0010; ready = '0; set_data(1, $urandom);
      repeat (2) cycle();
      valid = '0;
      cycle();
      checks++;
      if ({err_drop, first_type, first_chan, err_count} !== {4'b0010, 2'd1, 2'd1, 2'd1}) begin
         errors++;
         $display("FAIL drop: got drop=%b ft=%0d fc=%0d cnt=%0d want 0010 1 1 1",
                  err_drop, first_type, first_chan, err_count);
      end
      err_clr = 1;
      cycle();
      err_clr = 0;
      checks++;
      if (dut_vec() !== '0) begin
         errors++; $display("FAIL drop_clear: got %h want 0", dut_vec());
      end
   endtask

   task automatic test_data_priority();
      valid = 4'b1001; ready = '0; set_data(3, 32'h1); set_data(0, $urandom);
      cycle();
      valid = 4'b1000; set_data(3, 32'h2);
      cycle();
      checks++;
      if ({err_data, err_drop, first_type, first_chan, err_count} !==
          {4'b1000, 4'b0001, 2'd1, 2'd0, 2'd1}) begin
         errors++;
         $display("FAIL data_prio: got data=%b drop=%b ft=%0d fc=%0d cnt=%0d want 1000 0001 1 0 1",
                  err_data, err_drop, first_type, first_chan, err_count);
      end
      ready = 4'b1000;
      cycle();
      checks++;
      if (dut_vec() !== model_vec()) begin
         errors++; $display("FAIL data_hs: got %h want %h", dut_vec(), model_vec());
      end
      idle_inputs(); err_clr = 1;
      cycle();
      err_clr = 0;
      checks++;
      if (dut_vec() !== '0) begin
         errors++; $display("FAIL data_clear: got %h want 0", dut_vec());
      end
   endtask

   task automatic test_timeout();
      valid = 4'b0001; ready = '0; set_data(0, 32'hC0DE_0001);
      for (int k = 1; k <= 10; k++) begin
         cycle();
         checks++;
         if ({err_timeout, err_count} !== {(k >= 4) ? 4'b0001 : 4'b0000, (k >= 4) ? 2'd1 : 2'd0}) begin
            errors++;
            $display("FAIL timeout_k%0d: got to=%b cnt=%0d want to=%b cnt=%0d",
                     k, err_timeout, err_count, (k >= 4) ? 4'b0001 : 4'b0000, (k >= 4) ? 1 : 0);
         end
      end
      valid = 4'b0011; ready = 4'b0011; err_clr = 1;
      cycle();
      err_clr = 0;
      checks++;
      if ({err_mutex, err_timeout, err_count, first_type} !== {1'b1, 4'b0000, 2'd1, 2'd0}) begin
         errors++;
         $display("FAIL clr_vs_event: got m=%b to=%b cnt=%0d ft=%0d want 1 0000 1 0",
                  err_mutex, err_timeout, err_count, first_type);
      end
      idle_inputs(); err_clr = 1;
      cycle();
      err_clr = 0;
   endtask

   task automatic test_saturate();
      for (int k = 1; k <= 5; k++) begin
         valid = 4'b1100; ready = 4'b1100;
         cycle();
         checks++;
         if (err_count !== CNT_W'((k < CNT_MAX) ? k : CNT_MAX)) begin
            errors++;
            $display("FAIL saturate_k%0d: got %0d want %0d", k, err_count, (k < CNT_MAX) ? k : CNT_MAX);
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid_wait();
      valid = 4'b0010; ready = '0; set_data(1, 32'h1234_5678);
      repeat (2) cycle();
      #3;
      reset = 1;
      #1;
      checks++;
      if (dut_vec() !== '0) begin
         errors++; $display("FAIL async_reset: got %h want 0", dut_vec());
      end
      cycle();
      reset = 0; valid = '0;
      cycle();
      checks++;
      if (dut_vec() !== '0) begin
         errors++; $display("FAIL reset_no_drop: got %h want 0", dut_vec());
      end
   endtask

   task automatic test_chk_dis();
      valid = 4'b0011; ready = 4'b0011;
      cycle();
      valid = 4'b0100; ready = '0;
      cycle();
      chk_dis = 1; valid = 4'b0111; ready = 4'b0011;
      cycle();
      checks++;
      if ({err_mutex, err_drop, err_count} !== {1'b1, 4'b0000, 2'd1}) begin
         errors++;
         $display("FAIL chk_dis_hold: got m=%b drop=%b cnt=%0d want 1 0000 1", err_mutex, err_drop, err_count);
      end
      chk_dis = 0; valid = '0; ready = '0;
      cycle();
      checks++;
      if (dut_vec() !== model_vec() || err_drop !== 4'b0000) begin
         errors++; $display("FAIL chk_dis_fresh: got %h want %h", dut_vec(), model_vec());
      end
      err_clr = 1;
      cycle();
      err_clr = 0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 2500; n++) begin
         for (int i = 0; i < NCH; i++) begin
            valid[i] = m_wait[i] ? ($urandom_range(15) != 0) : ($urandom_range(2) == 0);
            ready[i] = ($urandom_range(3) == 0);
            if ($urandom_range(7) == 0) set_data(i, DATA_W'($urandom_range(3)));
         end
         err_clr = ($urandom_range(19) == 0);
         chk_dis = ($urandom_range(39) == 0);
         cycle();
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL random_n%0d: got %h want %h", n, dut_vec(), model_vec());
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_mutex();
      test_handshake();
      test_drop();
      test_data_priority();
      test_timeout();
      test_saturate();
      test_reset_mid_wait();
      test_chk_dis();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
